// File: rtl/h_key_power_sequencer.sv
// Captures the GHASH hash key H and computes H^1..H^N_BLOCKS into a register bank, one
// GF(2^128) multiply per clock; o_valid marks the table consistent with the captured key.
module h_key_power_sequencer #(
  parameter int NB_BLOCK = 128,
  parameter int N_BLOCKS = 2,
  parameter int NB_DATA  = NB_BLOCK * N_BLOCKS
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [NB_BLOCK-1:0] i_h_key,
  input  logic                i_h_key_load,
  output logic [NB_DATA-1:0]  o_h_key_powers,
  output logic                o_valid,
  output logic                o_busy
);

  localparam int CW = $clog2(N_BLOCKS) + 1;

  generate
    if (NB_BLOCK != 128 || N_BLOCKS < 1 || N_BLOCKS > 16 ||
        NB_DATA != NB_BLOCK * N_BLOCKS) begin : g_bad_cfg
      $error("h_key_power_sequencer: unsupported NB_BLOCK/N_BLOCKS/NB_DATA");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [NB_BLOCK-1:0] h_q;
  logic [NB_BLOCK-1:0] slot_q [N_BLOCKS];
  logic                valid_q;
  logic                busy_q;
  logic [NB_BLOCK-1:0] mul_a;
  logic [NB_BLOCK-1:0] pow_d;

  // Bit-reflected operands: index j carries x^(127-j), so product index m carries x^(254-m).
  function automatic logic [254:0] clmul(input logic [127:0] a, input logic [127:0] b);
    logic [254:0] p;
    p = '0;
    for (int j = 0; j < 128; j++) begin
      if (a[j]) begin
        p[j +: 128] = p[j +: 128] ^ b;
      end
    end
    return p;
  endfunction

  // Folds x^128..x^254 (indices 126..0) down via x^128 = x^7+x^2+x+1, highest degree first,
  // so terms folded back above x^127 are picked up later in the same pass.
  function automatic logic [127:0] reduce(input logic [254:0] p_in);
    logic [254:0] p;
    p = p_in;
    for (int m = 0; m < 127; m++) begin
      if (p[m]) begin
        p[m + 121] = ~p[m + 121];
        p[m + 126] = ~p[m + 126];
        p[m + 127] = ~p[m + 127];
        p[m + 128] = ~p[m + 128];
      end
    end
    return p[254:127];
  endfunction

  always_comb begin
    mul_a = '0;
    for (int i = 0; i < N_BLOCKS; i++) begin
      if (cnt_q == CW'(i + 1)) begin
        mul_a = slot_q[i];
      end
    end
    pow_d = reduce(clmul(mul_a, h_q));
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      h_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < N_BLOCKS; i++) begin
        slot_q[i] <= '0;
      end
    end else if (i_h_key_load) begin
      // A load restarts from any state and wipes every slot of the previous key.
      h_q       <= i_h_key;
      slot_q[0] <= i_h_key;
      for (int i = 1; i < N_BLOCKS; i++) begin
        slot_q[i] <= '0;
      end
      cnt_q <= CW'(1);
      if (N_BLOCKS > 1) begin
        state_q <= S_CALC;
        valid_q <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        state_q <= S_DONE;
        valid_q <= 1'b1;
        busy_q  <= 1'b0;
      end
    end else if (state_q == S_CALC) begin
      for (int i = 1; i < N_BLOCKS; i++) begin
        if (cnt_q == CW'(i)) begin
          slot_q[i] <= pow_d;
        end
      end
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CW'(N_BLOCKS - 1)) begin
        state_q <= S_DONE;
        valid_q <= 1'b1;
        busy_q  <= 1'b0;
      end
    end
  end

  generate
    for (genvar g = 0; g < N_BLOCKS; g++) begin : g_pack
      assign o_h_key_powers[g*NB_BLOCK +: NB_BLOCK] = slot_q[g];
    end
  endgenerate

  assign o_valid = valid_q;
  assign o_busy  = busy_q;

endmodule

// File: doc/h_key_power_sequencer.md
# h_key_power_sequencer

Sequential generator and holder of the GHASH hash-key power table H^1..H^N_BLOCKS. It sits between the hash-key source and the GHASH core. It captures H on a load pulse and computes one power per clock with a single GF(2^128) multiplier: the `multiplier_without_pipe` product followed by `gf_2to128_multiplier_booth1_subrem` reduction. Results go into a register bank that drives the core. A valid flag tells the core when the table is consistent.

## Interface
Parameters:
- NB_BLOCK, 128, field element width; any other value is a bad configuration.
- N_BLOCKS, 2, number of powers held; legal range 1..16.
- NB_DATA, NB_BLOCK*N_BLOCKS, width of the packed table output.

Ports:
- i_clock  input  1  single clock; all state updates on its rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_h_key  input  NB_BLOCK  hash key H in GCM bit-reflected convention (MSB = x^0).
- i_h_key_load  input  1  single-cycle load strobe; i_h_key is sampled when the strobe is high.
- o_h_key_powers  output  NB_DATA  registered table; slot i at bits [i*NB_BLOCK +: NB_BLOCK] holds H^(i+1).
- o_valid  output  1  high when every slot holds the power of the current captured key.
- o_busy  output  1  high while powers are being computed.

## Operation
- Field arithmetic: GF(2^128), polynomial x^128+x^7+x^2+x+1, same bit convention as the GHASH core.
- Product width: the raw product is 255 bits. The result is bits [254:127] XOR the reduction of bits [126:0].
- Internal state:
  - h_reg: captured key.
  - slot[0..N_BLOCKS-1]: power registers.
  - cnt: ceil(log2(N_BLOCKS))+1 bits.
  - state: IDLE, CALC, DONE.
- Reset, asynchronous:
  - state=IDLE, cnt=0, h_reg=0, all slots=0.
  - o_valid=0, o_busy=0, o_h_key_powers=0.
- IDLE/DONE on i_h_key_load=1:
  - h_reg←i_h_key, slot[0]←i_h_key, slots 1..N_BLOCKS-1←0, cnt←1, o_valid←0.
  - Next state is CALC if N_BLOCKS>1. Otherwise DONE with o_valid←1.
- CALC, each cycle without load:
  - slot[cnt]←reduce(slot[cnt-1]·h_reg), cnt←cnt+1.
  - When cnt==N_BLOCKS-1 is written: state←DONE, o_valid←1, o_busy←0.
- CALC on i_h_key_load=1: abort and restart exactly as the IDLE load, using the new key. No partially computed slot of the old key survives.
- DONE: the table is held indefinitely, and o_valid stays 1 until the next load or reset.
- h_reg is the multiplier operand, not i_h_key. Changes on i_h_key after the load cycle have no effect.
- o_busy = (state==CALC).
- Combinational path: one full multiply plus reduction, slot-to-slot, within one cycle. No multicycle constraint is allowed.

## Timing
- Load sampled at edge k:
  - slot[0] is visible after edge k.
  - slot[i] is visible after edge k+i.
  - o_valid rises after edge k+N_BLOCKS-1, giving latency N_BLOCKS-1 cycles after capture.
  - For N_BLOCKS=1, o_valid rises after edge k itself.
- o_valid falls after the same edge that samples a load. The core must not use the table while o_valid=0.
- Back-to-back loads: each load restarts, and only the last one completes.
- Reset asserted mid-CALC: all outputs go to zero immediately (asynchronous). On release the state is IDLE, and a new load is required.
- Reset and load in the same cycle: reset wins; the load is ignored.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset state: assert i_reset mid-run with N_BLOCKS=4 -> o_h_key_powers=0, o_valid=0, o_busy=0 at once; they stay there after release until a load.
- Unit element: N_BLOCKS=4, load H=0x8000…0 (x^0) -> after 3 cycles o_valid=1 and all four slots =0x8000…0.
- Monomial powers: N_BLOCKS=4, load H=0x4000…0 (x^1) -> slots 0x4000…0, 0x2000…0, 0x1000…0, 0x0800…0. o_busy is high for exactly 3 cycles.
- Zero key and N_BLOCKS=1: N_BLOCKS=2 with H=0 gives both slots 0 and o_valid=1 after 1 cycle. N_BLOCKS=1 with H=0x4000…0 gives o_valid=1 in the cycle after load, with o_busy never high.
- Restart: N_BLOCKS=8, load H_a, then load H_b 3 cycles later -> o_valid drops, and 7 cycles after the second load all slots match golden-model powers of H_b. No H_a value remains.
- Random keys: 1000 random H, N_BLOCKS=8, with i_h_key toggled randomly after load -> every slot matches a software GF(2^128) model (GCM reflected) once o_valid=1.
